// File: rtl/pid_calc_if.sv
// Bundle between the attitude-error stage, the PID output stage and the motor mixer.
// The master drives the strobe, the errors and the gains. The slave returns the corrections and status.
interface pid_calc_if;
  logic                pid_en;
  logic signed [15:0]  pitch_error;
  logic signed [15:0]  roll_error;
  logic signed [15:0]  yaw_error;
  logic signed [15:0]  i_pitch_error;
  logic signed [15:0]  i_roll_error;
  logic signed [15:0]  i_yaw_error;
  logic signed [15:0]  d_pitch_error;
  logic signed [15:0]  d_roll_error;
  logic signed [15:0]  d_yaw_error;
  logic signed [15:0]  kp_pr;
  logic signed [15:0]  ki_pr;
  logic signed [15:0]  kd_pr;
  logic signed [15:0]  kp_yaw;
  logic signed [15:0]  ki_yaw;
  logic signed [15:0]  kd_yaw;
  logic signed [15:0]  pitch_out;
  logic signed [15:0]  roll_out;
  logic signed [15:0]  yaw_out;
  logic                pid_busy;
  logic                pid_done;

  modport master (
    output pid_en,
    output pitch_error, roll_error, yaw_error,
    output i_pitch_error, i_roll_error, i_yaw_error,
    output d_pitch_error, d_roll_error, d_yaw_error,
    output kp_pr, ki_pr, kd_pr, kp_yaw, ki_yaw, kd_yaw,
    input  pitch_out, roll_out, yaw_out, pid_busy, pid_done
  );

  modport slave (
    input  pid_en,
    input  pitch_error, roll_error, yaw_error,
    input  i_pitch_error, i_roll_error, i_yaw_error,
    input  d_pitch_error, d_roll_error, d_yaw_error,
    input  kp_pr, ki_pr, kd_pr, kp_yaw, ki_yaw, kd_yaw,
    output pitch_out, roll_out, yaw_out, pid_busy, pid_done
  );
endinterface

// File: rtl/pid_calc.sv
// PID output stage. One shared signed 16x16 multiplier accumulates Kp*e + Ki*ie + Kd*de per axis over nine cycles.
// Each axis sum is floor-scaled by SHIFT, clamped to +/-OUT_LIMIT, and all three outputs are published together.
module pid_calc #(
  parameter int SHIFT     = 8,
  parameter int OUT_LIMIT = 10000
) (
  input logic       clk,
  input logic       rst_n,
  pid_calc_if.slave pid
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;
  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(OUT_LIMIT);
  localparam logic signed [ACC_W-1:0] LIM_LO = -LIM_HI;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] idx_q;
  logic signed [ACC_W-1:0] acc_p1;

  logic signed [DATA_W-1:0] pe_h, re_h, ye_h, pi_h, ri_h, yi_h, pd_h, rd_h, yd_h;
  logic signed [COEF_W-1:0] kp_pr_h, ki_pr_h, kd_pr_h, kp_yaw_h, ki_yaw_h, kd_yaw_h;

  logic signed [DATA_W-1:0] op_e_p0;
  logic signed [COEF_W-1:0] op_k_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  sum_p0;
  logic signed [DATA_W-1:0] axis_res_p0;
  logic first_of_axis, last_of_axis, start;

  logic signed [DATA_W-1:0] sh_pitch, sh_roll, sh_yaw;

  function automatic logic signed [ACC_W-1:0] scale_floor(input logic signed [ACC_W-1:0] v);
    return v >>> SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > LIM_HI) return DATA_W'(LIM_HI);
    if (v < LIM_LO) return DATA_W'(LIM_LO);
    return v[DATA_W-1:0];
  endfunction

  assign start         = (state_q == S_IDLE) && pid.pid_en;
  assign first_of_axis = (idx_q == 4'd0) || (idx_q == 4'd3) || (idx_q == 4'd6);
  assign last_of_axis  = (idx_q == 4'd2) || (idx_q == 4'd5) || (idx_q == 4'd8);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pid.pid_en) state_d = S_MAC;
      S_MAC:   if (idx_q == 4'd8) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pid.pid_busy = (state_q != S_IDLE);
  assign pid.pid_done = (state_q == S_DONE);

  // Holding registers: captured only on an accepted strobe, so upstream may move freely during MAC
  always_ff @(posedge clk) begin
    if (start) begin
      pe_h     <= pid.pitch_error;
      re_h     <= pid.roll_error;
      ye_h     <= pid.yaw_error;
      pi_h     <= pid.i_pitch_error;
      ri_h     <= pid.i_roll_error;
      yi_h     <= pid.i_yaw_error;
      pd_h     <= pid.d_pitch_error;
      rd_h     <= pid.d_roll_error;
      yd_h     <= pid.d_yaw_error;
      kp_pr_h  <= pid.kp_pr;
      ki_pr_h  <= pid.ki_pr;
      kd_pr_h  <= pid.kd_pr;
      kp_yaw_h <= pid.kp_yaw;
      ki_yaw_h <= pid.ki_yaw;
      kd_yaw_h <= pid.kd_yaw;
    end
  end

  // Stage p0: operand select, shared multiplier, axis accumulate and finalise
  always_comb begin
    op_e_p0 = '0;
    op_k_p0 = '0;
    case (idx_q)
      4'd0:    begin op_e_p0 = pe_h; op_k_p0 = kp_pr_h;  end
      4'd1:    begin op_e_p0 = pi_h; op_k_p0 = ki_pr_h;  end
      4'd2:    begin op_e_p0 = pd_h; op_k_p0 = kd_pr_h;  end
      4'd3:    begin op_e_p0 = re_h; op_k_p0 = kp_pr_h;  end
      4'd4:    begin op_e_p0 = ri_h; op_k_p0 = ki_pr_h;  end
      4'd5:    begin op_e_p0 = rd_h; op_k_p0 = kd_pr_h;  end
      4'd6:    begin op_e_p0 = ye_h; op_k_p0 = kp_yaw_h; end
      4'd7:    begin op_e_p0 = yi_h; op_k_p0 = ki_yaw_h; end
      4'd8:    begin op_e_p0 = yd_h; op_k_p0 = kd_yaw_h; end
      default: begin op_e_p0 = '0;   op_k_p0 = '0;       end
    endcase
  end

  assign prod_p0     = PROD_W'(op_e_p0) * PROD_W'(op_k_p0);
  assign sum_p0      = (first_of_axis ? '0 : acc_p1) + ACC_W'(prod_p0);
  assign axis_res_p0 = sat_out(scale_floor(sum_p0));

  // Stage p1: accumulator, shadows, and the simultaneous publish of all three axes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q         <= '0;
      acc_p1        <= '0;
      sh_pitch      <= '0;
      sh_roll       <= '0;
      sh_yaw        <= '0;
      pid.pitch_out <= '0;
      pid.roll_out  <= '0;
      pid.yaw_out   <= '0;
    end else if (start) begin
      idx_q  <= '0;
      acc_p1 <= '0;
    end else if (state_q == S_MAC) begin
      idx_q  <= idx_q + 4'd1;
      acc_p1 <= sum_p0;
      if (last_of_axis) begin
        case (idx_q)
          4'd2: sh_pitch <= axis_res_p0;
          4'd5: sh_roll  <= axis_res_p0;
          default: begin
            sh_yaw        <= axis_res_p0;
            pid.pitch_out <= sh_pitch;
            pid.roll_out  <= sh_roll;
            pid.yaw_out   <= axis_res_p0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_calc.sv
// Bench for pid_calc: a vector table, a randomized run against an arithmetic reference,
// and hand-written sequences covering busy, input-stability and mid-run reset behaviour.
module tb_pid_calc;

  localparam int SHIFT     = 8;
  localparam int OUT_LIMIT = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pid_calc_if bus();

  pid_calc #(.SHIFT(SHIFT), .OUT_LIMIT(OUT_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pid   (bus)
  );

  typedef struct packed {
    logic signed [15:0] pe, pi, pd, re, ri, rd, ye, yi, yd;
    logic signed [15:0] kp, ki, kd, kpy, kiy, kdy;
    logic signed [15:0] xp, xr, xy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [6];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int axis_model(input int kp, input int ki, input int kd,
                                    input int e, input int ie, input int de);
    longint s, q, scale;
    scale = longint'(1) << SHIFT;
    s = longint'(kp) * e + longint'(ki) * ie + longint'(kd) * de;
    q = s / scale;
    if ((s % scale) != 0 && s < 0) q = q - 1;
    if (q > OUT_LIMIT) q = OUT_LIMIT;
    if (q < -OUT_LIMIT) q = -OUT_LIMIT;
    return int'(q);
  endfunction

  function automatic vec_t with_model(input vec_t v);
    vec_t r = v;
    r.xp = 16'(axis_model(v.kp,  v.ki,  v.kd,  v.pe, v.pi, v.pd));
    r.xr = 16'(axis_model(v.kp,  v.ki,  v.kd,  v.re, v.ri, v.rd));
    r.xy = 16'(axis_model(v.kpy, v.kiy, v.kdy, v.ye, v.yi, v.yd));
    return r;
  endfunction

  function automatic logic signed [15:0] rnd16();
    return 16'($urandom);
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.pe = rnd16(); v.pi = rnd16(); v.pd = rnd16();
    v.re = rnd16(); v.ri = rnd16(); v.rd = rnd16();
    v.ye = 16'($urandom_range(0, 4095)) - 16'sd2048;
    v.yi = 16'($urandom_range(0, 4095)) - 16'sd2048;
    v.yd = 16'($urandom_range(0, 4095)) - 16'sd2048;
    v.kp  = ($urandom_range(0, 3) == 0) ? rnd16() : 16'($urandom_range(0, 63)) - 16'sd32;
    v.ki  = 16'($urandom_range(0, 63)) - 16'sd32;
    v.kd  = 16'($urandom_range(0, 63)) - 16'sd32;
    v.kpy = 16'($urandom_range(0, 511)) - 16'sd256;
    v.kiy = 16'($urandom_range(0, 511)) - 16'sd256;
    v.kdy = 16'($urandom_range(0, 511)) - 16'sd256;
    return with_model(v);
  endfunction

  task automatic apply(input vec_t v);
    bus.pitch_error = v.pe; bus.i_pitch_error = v.pi; bus.d_pitch_error = v.pd;
    bus.roll_error  = v.re; bus.i_roll_error  = v.ri; bus.d_roll_error  = v.rd;
    bus.yaw_error   = v.ye; bus.i_yaw_error   = v.yi; bus.d_yaw_error   = v.yd;
    bus.kp_pr  = v.kp;  bus.ki_pr  = v.ki;  bus.kd_pr  = v.kd;
    bus.kp_yaw = v.kpy; bus.ki_yaw = v.kiy; bus.kd_yaw = v.kdy;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, " pitch_out"}, bus.pitch_out, v.xp);
    check({tag, " roll_out"},  bus.roll_out,  v.xr);
    check({tag, " yaw_out"},   bus.yaw_out,   v.xy);
  endtask

  // Strobe one sequence and verify 10-cycle latency, outputs, and a single-cycle done
  task automatic run_seq(input string tag, input vec_t v);
    int lat = 0;
    apply(v);
    bus.pid_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.pid_en = 1'b0;
        check({tag, " busy"}, int'(bus.pid_busy), 1);
      end
      if (bus.pid_done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, 10);
    check_outs(tag, v);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, int'(bus.pid_done), 0);
    check({tag, " busy after"}, int'(bus.pid_busy), 0);
  endtask

  initial begin
    vec_t a, b, c;
    int done_seen;

    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].kp = 256; tbl[0].kpy = 256;
    tbl[0].pe = 100; tbl[0].re = -200; tbl[0].ye = 300;
    tbl[0].xp = 100; tbl[0].xr = -200; tbl[0].xy = 300;
    tbl[1].kp = 512; tbl[1].ki = 128; tbl[1].kd = 256;
    tbl[1].pe = 40;  tbl[1].pi = 100; tbl[1].pd = -30;
    tbl[1].xp = 100; tbl[1].xr = 0;   tbl[1].xy = 0;
    tbl[2].kp = 32767; tbl[2].pe = 32767; tbl[2].re = -32768;
    tbl[2].kpy = 1; tbl[2].ye = -1;
    tbl[2].xp = 10000; tbl[2].xr = -10000; tbl[2].xy = -1;
    tbl[3].kp = 1; tbl[3].pe = 1; tbl[3].re = -1;
    tbl[3].kpy = 32767; tbl[3].ye = -32768;
    tbl[3].xp = 0; tbl[3].xr = -1; tbl[3].xy = -10000;
    tbl[4].ki = -32768; tbl[4].pi = 32767; tbl[4].ri = -32768;
    tbl[4].kdy = 300; tbl[4].yd = -7;
    tbl[4].xp = -10000; tbl[4].xr = 10000; tbl[4].xy = -9;
    tbl[5].kp = 256; tbl[5].kpy = 256;
    tbl[5].pe = 10000; tbl[5].re = 10001; tbl[5].ye = -10001;
    tbl[5].xp = 10000; tbl[5].xr = 10000; tbl[5].xy = -10000;

    bus.pid_en = 1'b0;
    apply('0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pitch_out", bus.pitch_out, 0);
    check("reset roll_out",  bus.roll_out,  0);
    check("reset yaw_out",   bus.yaw_out,   0);
    check("reset busy", int'(bus.pid_busy), 0);
    check("reset done", int'(bus.pid_done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_seq($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 25; i++) run_seq($sformatf("rand%0d", i), rand_vec());

    // Busy strobe ignored, inputs scrambled during MAC, follow-up strobe at N+11
    a = tbl[0];
    b = tbl[2];
    c = rand_vec();
    apply(a);
    bus.pid_en = 1'b1;
    done_seen = 0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 5 || k == 12) bus.pid_en = 1'b0;
      if (k == 4) begin
        apply(b);
        bus.pid_en = 1'b1;
      end
      if (k >= 5 && k <= 9) apply(rand_vec());
      if (bus.pid_done && k != 10 && k != 21) done_seen++;
      if (k == 10) begin
        check("busy seq done", int'(bus.pid_done), 1);
        check_outs("busy seq", a);
      end
      if (k == 11) begin
        apply(c);
        bus.pid_en = 1'b1;
      end
      if (k == 21) begin
        check("restart done", int'(bus.pid_done), 1);
        check_outs("restart", c);
      end
    end
    check("stray done pulses", done_seen, 0);
    @(posedge clk); #1;

    // Reset mid-run discards the sequence and clears outputs
    apply(tbl[5]);
    bus.pid_en = 1'b1;
    done_seen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.pid_en = 1'b0;
      if (k == 5) rst_n = 1'b0;
      if (k == 6) begin
        rst_n = 1'b1;
        check("mid reset pitch_out", bus.pitch_out, 0);
        check("mid reset roll_out",  bus.roll_out,  0);
        check("mid reset yaw_out",   bus.yaw_out,   0);
        check("mid reset busy", int'(bus.pid_busy), 0);
      end
      if (bus.pid_done) done_seen++;
    end
    check("done after reset", done_seen, 0);
    run_seq("post reset", tbl[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
